// File: rtl/cla_pipe_adder_pkg.sv
// Shared configuration helpers and records for the pipelined carry-lookahead adder.
package cla_pipe_adder_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int BLOCK_DEF  = 4;
  localparam int STAGES_DEF = 2;

  // Status flags registered alongside the final sum.
  typedef struct packed {
    logic co;
    logic ovf;
  } flags_t;

  function automatic int ngroups(input int width, input int block);
    return width / block;
  endfunction

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Legal shapes: whole groups per slice and at least one group per stage.
  function automatic bit cfg_ok(input int width, input int block, input int stages);
    if (width < 1 || block < 1 || stages < 1) return 1'b0;
    if (width % (block * stages) != 0) return 1'b0;
    return stages <= width / block;
  endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
interface cla_pipe_adder_if
  import cla_pipe_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, x, y, ci, sub, out_ready,
    input  in_ready, out_valid, s, co, ovf
  );

  modport slave (
    input  in_valid, x, y, ci, sub, out_ready,
    output in_ready, out_valid, s, co, ovf
  );
endinterface

// File: rtl/cla_pipe_adder_block.sv
// BLOCK-bit lookahead group: bit sums from the group carry-in plus group generate/propagate.
module cla_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] x,
  input  logic [BLOCK-1:0] y,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             g,
  output logic             p
);
  logic [BLOCK-1:0] gi;
  logic [BLOCK-1:0] pi;
  logic [BLOCK-1:0] c;

  always_comb begin
    gi   = x & y;
    pi   = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 1; i < BLOCK; i++) c[i] = gi[i-1] | (pi[i-1] & c[i-1]);
    s = pi ^ c;
    // g/p ignore ci so the slice-level lookahead never waits on this group's carry-in.
    g = 1'b0;
    p = 1'b1;
    for (int i = 0; i < BLOCK; i++) begin
      g = gi[i] | (pi[i] & g);
      p = p & pi[i];
    end
  end
endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor: stage k resolves slice k, upper operands ride along skewed.
module cla_pipe_adder
  import cla_pipe_adder_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int BLOCK  = BLOCK_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input logic             clk,
  input logic             rst,
  cla_pipe_adder_if.slave bus
);
  localparam int NGROUPS = ngroups(WIDTH, BLOCK);
  localparam int SLICE   = slice_w(WIDTH, STAGES);
  localparam int GPS     = NGROUPS / STAGES;

  if (!cfg_ok(WIDTH, BLOCK, STAGES)) begin : g_cfg_err
    $error("cla_pipe_adder: WIDTH must be a multiple of BLOCK*STAGES and STAGES <= WIDTH/BLOCK");
  end

  // Per-stage operand view (what stage k computes from) and stage registers.
  logic [WIDTH-1:0]  xa   [STAGES];
  logic [WIDTH-1:0]  ya   [STAGES];
  logic [WIDTH-1:0]  sa   [STAGES];
  logic              ca   [STAGES];
  logic [WIDTH-1:0]  x_p  [STAGES];
  logic [WIDTH-1:0]  y_p  [STAGES];
  logic [WIDTH-1:0]  s_p  [STAGES];
  logic              cy_p [STAGES];
  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] va;
  logic [STAGES-1:0] rdy;
  flags_t            flg_q;

  // A stage may load when it is empty or its content moves on this cycle.
  always_comb begin
    rdy = ~vld_p;
    rdy[STAGES-1] = ~vld_p[STAGES-1] | bus.out_ready;
    for (int k = STAGES - 2; k >= 0; k--) rdy[k] = ~vld_p[k] | rdy[k+1];
  end

  always_comb begin
    va    = vld_p << 1;
    va[0] = bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p <= '0;
    else     vld_p <= (vld_p & ~rdy) | (va & rdy);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [GPS:0]     gc;
    logic [GPS-1:0]   gg;
    logic [GPS-1:0]   gp;
    logic [SLICE-1:0] ss;
    logic [WIDTH-1:0] sn;
    logic             ld;

    // Subtraction folds into the first stage as x + ~y + ~ci.
    if (k == 0) begin : g_in
      assign xa[k] = bus.x;
      assign ya[k] = bus.y ^ {WIDTH{bus.sub}};
      assign sa[k] = '0;
      assign ca[k] = bus.ci ^ bus.sub;
    end else begin : g_fwd
      assign xa[k] = x_p[k-1];
      assign ya[k] = y_p[k-1];
      assign sa[k] = s_p[k-1];
      assign ca[k] = cy_p[k-1];
    end

    for (genvar j = 0; j < GPS; j++) begin : g_grp
      cla_block #(.BLOCK(BLOCK)) u_blk (
        .x  (xa[k][k*SLICE + j*BLOCK +: BLOCK]),
        .y  (ya[k][k*SLICE + j*BLOCK +: BLOCK]),
        .ci (gc[j]),
        .s  (ss[j*BLOCK +: BLOCK]),
        .g  (gg[j]),
        .p  (gp[j])
      );
    end

    always_comb begin
      gc    = '0;
      gc[0] = ca[k];
      for (int j = 0; j < GPS; j++) gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end

    always_comb begin
      sn = sa[k];
      sn[k*SLICE +: SLICE] = ss;
    end

    assign ld = rdy[k] & va[k];

    // ---- stage k register boundary ----
    if (k < STAGES - 1) begin : g_mid
      always_ff @(posedge clk) begin
        if (ld) begin
          x_p[k]  <= xa[k];
          y_p[k]  <= ya[k];
          s_p[k]  <= sn;
          cy_p[k] <= gc[GPS];
        end
      end
    end else begin : g_out
      logic cmsb;
      // Carry into the MSB recovered from the MSB sum bit.
      assign cmsb = xa[k][WIDTH-1] ^ ya[k][WIDTH-1] ^ ss[SLICE-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          s_p[k] <= '0;
          flg_q  <= '0;
        end else if (ld) begin
          s_p[k]    <= sn;
          flg_q.co  <= gc[GPS];
          flg_q.ovf <= gc[GPS] ^ cmsb;
        end
      end
    end
  end

  assign bus.in_ready  = rdy[0] & ~rst;
  assign bus.out_valid = vld_p[STAGES-1];
  assign bus.s         = s_p[STAGES-1];
  assign bus.co        = flg_q.co;
  assign bus.ovf       = flg_q.ovf;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: main STAGES=2 instance plus STAGES=1/4/8 latency sweep.
module tb_cla_pipe_adder;
  localparam int W  = 32;
  localparam int ST = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(W)) bus  ();
  cla_pipe_adder_if #(.WIDTH(W)) bus1 ();
  cla_pipe_adder_if #(.WIDTH(W)) bus4 ();
  cla_pipe_adder_if #(.WIDTH(W)) bus8 ();

  cla_pipe_adder #(.WIDTH(W), .BLOCK(4), .STAGES(ST)) dut  (.clk(clk), .rst(rst), .bus(bus));
  cla_pipe_adder #(.WIDTH(W), .BLOCK(4), .STAGES(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1));
  cla_pipe_adder #(.WIDTH(W), .BLOCK(4), .STAGES(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));
  cla_pipe_adder #(.WIDTH(W), .BLOCK(4), .STAGES(8))  dut8 (.clk(clk), .rst(rst), .bus(bus8));

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
    int           t_in;
  } exp_t;

  exp_t exp_q[$];
  int   nchk  = 0;
  int   nerr  = 0;
  int   cyc   = 0;
  int   npop  = 0;
  logic chk_lat = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain wide addition, overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic sb);
    logic [W-1:0] bb;
    logic [W:0]   r;
    exp_t         e;
    bb    = sb ? ~b : b;
    r     = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sb ? ~c : c)};
    e.s   = r[W-1:0];
    e.co  = r[W];
    e.ovf = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    e.t_in = 0;
    return e;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'(bus.s), 64'hDEAD_0000_0000_0000);
      end else begin
        e = exp_q.pop_front();
        check("sum", 64'(bus.s), 64'(e.s));
        check("co",  64'(bus.co), 64'(e.co));
        check("ovf", 64'(bus.ovf), 64'(e.ovf));
        if (chk_lat) check("latency", 64'(cyc - e.t_in), 64'(ST));
        npop++;
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that took the operand.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic sb);
    exp_t e;
    int   n;
    bus.in_valid = 1'b1;
    bus.x = a;
    bus.y = b;
    bus.ci = c;
    bus.sub = sb;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("send_timeout", 64'(bus.in_ready), 64'd1);
    end else begin
      e = model(a, b, c, sb);
      e.t_in = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic sw_drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    bus1.in_valid = v; bus1.x = a; bus1.y = b; bus1.ci = 1'b0; bus1.sub = 1'b0; bus1.out_ready = 1'b1;
    bus4.in_valid = v; bus4.x = a; bus4.y = b; bus4.ci = 1'b0; bus4.sub = 1'b0; bus4.out_ready = 1'b1;
    bus8.in_valid = v; bus8.x = a; bus8.y = b; bus8.ci = 1'b0; bus8.sub = 1'b0; bus8.out_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] hold_s;
    logic [W-1:0] saved_x;
    logic         hold_co;
    int           pops0;
    int           t0;
    int           lat1, lat4, lat8;
    logic [W-1:0] s1, s4, s8;
    logic         o1, o4, o8;
    exp_t         sw_e;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.ci = 1'b0; bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    sw_drive(1'b0, '0, '0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_s",         64'(bus.s), 64'd0);
    check("rst_co",        64'(bus.co), 64'd0);
    check("rst_ovf",       64'(bus.ovf), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed boundaries and random back-to-back stream
    chk_lat = 1'b1;
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++)
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain("drain_b2b");
    chk_lat = 1'b0;

    // Back-pressure: consumer stalls while the producer keeps offering
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < ST + 2; i++) send($urandom, $urandom, 1'b0, 1'(i % 2));
      end
      begin
        repeat (8) @(negedge clk);
        check("stall_accepts",   64'(exp_q.size()), 64'(ST));
        check("stall_in_ready",  64'(bus.in_ready), 64'd0);
        check("stall_out_valid", 64'(bus.out_valid), 64'd1);
        hold_s  = bus.s;
        hold_co = bus.co;
        saved_x = bus.x;
        #1 bus.x = ~saved_x;
        repeat (4) @(negedge clk);
        check("stall_s_stable",  64'(bus.s), 64'(hold_s));
        check("stall_co_stable", 64'(bus.co), 64'(hold_co));
        check("stall_head",      64'(bus.s), 64'(exp_q[0].s));
        @(posedge clk);
        #1;
        bus.x = saved_x;
        bus.out_ready = 1'b1;
      end
    join
    drain("drain_stall");

    // Reset with two operations in flight
    bus.out_ready = 1'b0;
    send(32'd11, 32'd22, 1'b0, 1'b0);
    send(32'd33, 32'd44, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_s",         64'(bus.s), 64'd0);
    check("midrst_co",        64'(bus.co), 64'd0);
    check("midrst_ovf",       64'(bus.ovf), 64'd0);
    exp_q.delete();
    pops0 = npop;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send(32'd3, 32'd4, 1'b0, 1'b0);
    drain("drain_post_rst");
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_results", 64'(npop - pops0), 64'd1);

    // Depth sweep: latency tracks STAGES, overflow on 0x7FFFFFFF + 1
    sw_drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
    @(negedge clk);
    check("sw_in_ready", 64'({bus1.in_ready, bus4.in_ready, bus8.in_ready}), 64'b111);
    t0 = cyc;
    @(posedge clk);
    #1 sw_drive(1'b0, '0, '0);
    lat1 = -1; lat4 = -1; lat8 = -1;
    s1 = '0; s4 = '0; s8 = '0; o1 = 1'b0; o4 = 1'b0; o8 = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus1.out_valid && lat1 < 0) begin lat1 = cyc - t0; s1 = bus1.s; o1 = bus1.ovf; end
      if (bus4.out_valid && lat4 < 0) begin lat4 = cyc - t0; s4 = bus4.s; o4 = bus4.ovf; end
      if (bus8.out_valid && lat8 < 0) begin lat8 = cyc - t0; s8 = bus8.s; o8 = bus8.ovf; end
    end
    sw_e = model(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check("sw1_latency", 64'(lat1), 64'd1);
    check("sw4_latency", 64'(lat4), 64'd4);
    check("sw8_latency", 64'(lat8), 64'd8);
    check("sw1_sum", 64'(s1), 64'(sw_e.s));
    check("sw4_sum", 64'(s4), 64'(sw_e.s));
    check("sw8_sum", 64'(s8), 64'(sw_e.s));
    check("sw1_ovf", 64'(o1), 64'(sw_e.ovf));
    check("sw4_ovf", 64'(o4), 64'(sw_e.ovf));
    check("sw8_ovf", 64'(o8), 64'(sw_e.ovf));

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
